// File: rtl/mod5_frame_tx.sv
// mod5_frame_tx
//   Serial frame transmitter for a divisible-by-5 link. A parallel payload word
//   is shifted out MSB first and followed by a 3-bit suffix. The suffix is chosen
//   so that the whole DATA_W+3 bit frame, read MSB first as an unsigned number,
//   is a multiple of 5.
//
// Parameters
//   DATA_W      payload width in bits (>= 1)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         payload word, sampled on accept
//   din_valid   payload present on din
//   din_ready   block can accept din this cycle (combinational from state)
//   dout        serial frame bit, MSB first, 0 whenever dout_valid is low
//   dout_valid  dout carries a frame bit this cycle
//   dout_last   final (suffix LSB) bit of the frame
//   busy        frame in progress
//   tx_residue  (only with MOD5_RESIDUE_OUT_EN) running mod-5 residue of the
//               frame bits emitted so far, including the bit now on dout
//
// Build option
//   MOD5_RESIDUE_OUT_EN  adds the tx_residue port and its residue checker.

`ifdef MOD5_RESIDUE_OUT_EN
// Residue checker: a complete frame must always leave the residue at zero.
module mod5_frame_tx_chk (
    input logic       clk,
    input logic       reset,
    input logic       dout_last,
    input logic [2:0] tx_residue
);

    // Final frame bit must close the residue to zero.
    a_last_residue_zero: assert property (
        @(posedge clk) disable iff (reset) dout_last |-> (tx_residue == 3'd0)
    );

endmodule
`endif

module mod5_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy
`ifdef MOD5_RESIDUE_OUT_EN
    ,
    output logic [2:0]        tx_residue
`endif
);

    // Counter must reach DATA_W-1 in DATA and 2 in SUFFIX.
    localparam int CNT_W = $clog2(DATA_W + 3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_SUFFIX = 2'd2
    } state_t;

    // One receiver step: residue of (2*r + b) mod 5 for r in 0..4.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [3:0] t;
        t = {r, 1'b0} + {3'b000, b};
        if (t >= 4'd5) begin
            t = t - 4'd5;
        end else begin
            t = t;
        end
        return t[2:0];
    endfunction

    // State describes the bit currently presented on dout; residue_r already
    // includes that bit, so it mirrors the downstream checker's running state.
    state_t             state_r,      state_s;
    logic [DATA_W-1:0]  shift_r,      shift_s;
    logic [2:0]         residue_r,    residue_s;
    logic [2:0]         suffix_r,     suffix_s;
    logic [CNT_W-1:0]   cnt_r,        cnt_s;
    logic               dout_r,       dout_s;
    logic               dout_valid_r, dout_valid_s;
    logic               dout_last_r,  dout_last_s;
    logic               busy_r,       busy_s;
    logic               accept_s;
    logic [2:0]         sfx_calc_s;

    // Ready in IDLE and in the last frame bit so frames can run back to back.
    assign din_ready = (state_r == ST_IDLE) || dout_last_r;
    assign accept_s  = din_valid && din_ready;

    // Next-state and next-output computation.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        residue_s    = residue_r;
        suffix_s     = suffix_r;
        cnt_s        = cnt_r;
        dout_s       = 1'b0;
        dout_valid_s = 1'b0;
        dout_last_s  = 1'b0;
        busy_s       = 1'b0;
        // Suffix uses the residue that already includes the last payload bit.
        sfx_calc_s   = mod5_step(residue_r, 1'b0);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s      = ST_DATA;
                    shift_s      = din << 1;
                    residue_s    = mod5_step(3'd0, din[DATA_W-1]);
                    cnt_s        = {CNT_W{1'b0}};
                    dout_s       = din[DATA_W-1];
                    dout_valid_s = 1'b1;
                    busy_s       = 1'b1;
                end else begin
                    state_s      = ST_IDLE;
                end
            end

            ST_DATA: begin
                dout_valid_s = 1'b1;
                busy_s       = 1'b1;
                if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_s   = ST_SUFFIX;
                    suffix_s  = sfx_calc_s;
                    cnt_s     = {CNT_W{1'b0}};
                    dout_s    = sfx_calc_s[2];
                    residue_s = mod5_step(residue_r, sfx_calc_s[2]);
                end else begin
                    shift_s   = shift_r << 1;
                    cnt_s     = cnt_r + CNT_W'(1);
                    dout_s    = shift_r[DATA_W-1];
                    residue_s = mod5_step(residue_r, shift_r[DATA_W-1]);
                end
            end

            ST_SUFFIX: begin
                if (cnt_r == CNT_W'(0)) begin
                    cnt_s        = CNT_W'(1);
                    dout_s       = suffix_r[1];
                    dout_valid_s = 1'b1;
                    busy_s       = 1'b1;
                    residue_s    = mod5_step(residue_r, suffix_r[1]);
                end else if (cnt_r == CNT_W'(1)) begin
                    cnt_s        = CNT_W'(2);
                    dout_s       = suffix_r[0];
                    dout_valid_s = 1'b1;
                    dout_last_s  = 1'b1;
                    busy_s       = 1'b1;
                    residue_s    = mod5_step(residue_r, suffix_r[0]);
                end else if (accept_s) begin
                    // Accept during dout_last: next frame starts without a gap.
                    state_s      = ST_DATA;
                    shift_s      = din << 1;
                    residue_s    = mod5_step(3'd0, din[DATA_W-1]);
                    cnt_s        = {CNT_W{1'b0}};
                    dout_s       = din[DATA_W-1];
                    dout_valid_s = 1'b1;
                    busy_s       = 1'b1;
                end else begin
                    state_s      = ST_IDLE;
                    shift_s      = {DATA_W{1'b0}};
                    residue_s    = 3'd0;
                    cnt_s        = {CNT_W{1'b0}};
                end
            end

            default: begin
                state_s   = ST_IDLE;
                shift_s   = {DATA_W{1'b0}};
                residue_s = 3'd0;
                suffix_s  = 3'd0;
                cnt_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shift_r      <= {DATA_W{1'b0}};
            residue_r    <= 3'd0;
            suffix_r     <= 3'd0;
            cnt_r        <= {CNT_W{1'b0}};
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            residue_r    <= residue_s;
            suffix_r     <= suffix_s;
            cnt_r        <= cnt_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            dout_last_r  <= dout_last_s;
            busy_r       <= busy_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign busy       = busy_r;

`ifdef MOD5_RESIDUE_OUT_EN
    assign tx_residue = residue_r;

    mod5_frame_tx_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .dout_last  (dout_last_r),
        .tx_residue (residue_r)
    );
`endif

endmodule

// File: doc/mod5_frame_tx.md
Name: mod5_frame_tx

Overview:
- Serial transmitter producing frames that a divisible-by-5 bit-stream checker accepts.
- Takes a parallel word and shifts it out MSB-first, then appends a 3-bit suffix chosen so the whole frame, read as an unsigned MSB-first number, is divisible by 5.
- Sits upstream of the mod-5 serial checker; used as the stimulus and source end of that link.

Parameters:
- DATA_W, 8, payload width in bits (≥1); frame length is DATA_W+3 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  payload word.
- din_valid  input  1  payload present on din.
- din_ready  output  1  block can accept din this cycle.
- dout  output  1  serial data bit, MSB first.
- dout_valid  output  1  dout carries a frame bit this cycle.
- dout_last  output  1  final (suffix LSB) bit of frame.
- busy  output  1  frame in progress.

Interface decision (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset: state IDLE, shift register 0, residue 0, bit counter 0. Outputs after reset: dout=0, dout_valid=0, dout_last=0, busy=0, din_ready=1.
- All outputs except din_ready are registered. din_ready is combinational from state.
- Accept: a handshake occurs on a cycle where din_valid && din_ready. din is latched into the shift register, residue clears to 0 and state becomes DATA.
- Latency: the MSB of din appears on dout with dout_valid=1 in the cycle after acceptance.
- State IDLE:
  - din_ready=1, dout_valid=0, dout=0.
  - Go to DATA on accept; otherwise stay in IDLE.
- State DATA:
  - Emits DATA_W bits, one per cycle, MSB first.
  - For each emitted bit b: residue <= (2*residue + b) mod 5, values 0..4, in a 3-bit register.
  - After the DATA_W-th bit, compute suffix s = (2*residue) mod 5, using the residue including that last bit. Go to SUFFIX.
- State SUFFIX:
  - Emits s[2:0] MSB first over 3 cycles. s ≤ 4, so s[2:0] always fits.
  - dout_last=1 on the third suffix bit only.
  - Correctness: payload*8 + s ≡ 0 mod 5, because 8 ≡ 3 and 3*2r ≡ r... ≡ 0 for all r.
- busy=1 from the cycle after acceptance through the dout_last cycle inclusive.
- din_ready=1 in IDLE and also in the dout_last cycle. An accept in the dout_last cycle starts the next frame with no gap: next cycle is the new MSB, state DATA.
- No accept in the dout_last cycle: return to IDLE, dout_valid=0 next cycle.
- din_ready=0 in all other DATA/SUFFIX cycles. din_valid is ignored there and din is not sampled.
- No back-pressure on the serial side: once started, a frame is always emitted as DATA_W+3 consecutive valid bits.
- Reset mid-frame: the frame is aborted with no partial suffix. The next cycle matches the reset values above.
- Reset wins over a simultaneous accept.
- dout is forced to 0 whenever dout_valid=0.

Optional Feature:
- Macro: MOD5_RESIDUE_OUT_EN.
- Defined:
  - Adds output port tx_residue[2:0]: the registered mod-5 residue of all frame bits emitted so far, including suffix bits.
  - Updates in the same cycle each bit is valid on dout, mirroring the receiver's running state.
  - Must equal 0 in the dout_last cycle. Resets to 0 and clears at each accept.
  - Adds a simulation-only assertion that tx_residue==0 whenever dout_last=1.
- Not defined: port and assertion are absent; functional behaviour is otherwise identical.

Test Plan:
- DATA_W=8, din=8'h01 accepted → 11 valid bits 0000_0001_010 (value 10); dout_last on 11th bit; busy for 11 cycles.
- din=8'h07 → suffix 100, frame value 60. din=8'h0D → suffix 001, frame value 105. din=8'hFF and din=8'h00 → suffix 000.
- din_valid held high with a new word each accept → frames back-to-back with no idle cycle. din_ready high only in IDLE and dout_last cycles; second frame's MSB immediately follows the first frame's dout_last.
- reset asserted on the 5th data bit of din=8'hA5 → next cycle dout_valid=0, busy=0, din_ready=1. A following din=8'h02 yields 0000_0010_100 (value 20).
- din_valid toggled while busy with garbage data → ignored; the frame in flight is unchanged.
- Random din (≥1000 frames), serial output fed into a reference mod-5 checker → checker reports divisible on every dout_last bit. With MOD5_RESIDUE_OUT_EN, tx_residue==0 on each dout_last.
